// File: rtl/mul_rr_arbiter.sv
// Round-robin front end for a shared pipelined multiplier: grants one requester per
// cycle, tracks the issuing requester down a tag pipeline and returns its product.
module mul_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int RESULT_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mul_ea,
  output logic                          mul_eb,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  output logic                          mul_start,
  input  logic [2*DATA_WIDTH-1:0]       mul_p,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [2*DATA_WIDTH-1:0]       rsp_p,
  output logic [$clog2(RESULT_LAT+2)-1:0] inflight
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RESULT_LAT+2);

  logic [PW-1:0]                  ptr_q, ptr_d;
  logic                           issue;
  logic [PW-1:0]                  gnt_id;
  logic                           mul_start_q, mul_start_d;
  logic [RESULT_LAT-1:0]          vld_pipe_q, vld_pipe_d;
  logic [RESULT_LAT-1:0][PW-1:0]  id_pipe_q, id_pipe_d;
  logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [2*DATA_WIDTH-1:0]        rsp_p_q, rsp_p_d;
  logic [CW-1:0]                  inflight_q, inflight_d;

  // Grant search: walk downward so the requester closest above the pointer wins.
  // rst_n gates the grant so nothing is offered while the block is held in reset.
  always_comb begin
    int idx;
    idx       = 0;
    issue     = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (en && rst_n) begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (req_valid[idx]) begin
          issue  = 1'b1;
          gnt_id = idx[PW-1:0];
        end
      end
    end
    if (issue) begin
      req_ready[gnt_id] = 1'b1;
      mul_a = req_a[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      mul_b = req_b[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + 1'b1;
    mul_start_d = issue;

    vld_pipe_d[0] = issue;
    id_pipe_d[0]  = gnt_id;
    for (int i = 1; i < RESULT_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      id_pipe_d[i]  = id_pipe_q[i-1];
    end

    // Last tag stage lines up with the cycle mul_p carries that op's product.
    rsp_valid_d = '0;
    rsp_p_d     = rsp_p_q;
    if (vld_pipe_q[RESULT_LAT-1]) begin
      rsp_valid_d[id_pipe_q[RESULT_LAT-1]] = 1'b1;
      rsp_p_d = mul_p;
    end

    inflight_d = inflight_q;
    case ({issue, |rsp_valid_q})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mul_start_q <= 1'b0;
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_start_q <= mul_start_d;
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      inflight_q  <= inflight_d;
    end
  end

  assign mul_ea    = issue;
  assign mul_eb    = issue;
  assign mul_start = mul_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign inflight  = inflight_q;

endmodule
